// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// default bus widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts wait cycles of the current access and flags a
// timeout on the TIMEOUT-th cycle without mem_ready.
module mem_arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // A ready in the same cycle as the limit wins, so the timeout is gated by ready.
  assign timeout_o = busy_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (busy_i && !ready_i && !timeout_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port,
// data first. Optional access watchdog enabled by defining MEM_ARB_WATCHDOG_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              timeout;

`ifdef MEM_ARB_WATCHDOG_EN
  logic err_q;
  logic access_start;

  assign access_start = (state_q == IDLE) && (state_d != IDLE);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (access_start),
    .busy_i    (state_q != IDLE),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_timeout_param;

  assign unused_timeout_param = (TIMEOUT == 0);
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      // A requester still holding req during its own done pulse is not re-granted.
      IDLE: begin
        if (d_req && !d_done_q) begin
          state_d = DATA;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
        end else if (if_req && !if_done_q) begin
          state_d = FETCH;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          state_d    = IDLE;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
        end else if (timeout) begin
          state_d    = IDLE;
          if_done_d  = 1'b1;
          if_rdata_d = '0;
        end
      end
      DATA: begin
        if (mem_ready) begin
          state_d   = IDLE;
          d_done_d  = 1'b1;
          d_rdata_d = mem_rdata;
        end else if (timeout) begin
          state_d   = IDLE;
          d_done_d  = 1'b1;
          d_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == DATA) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; watchdog scenario runs when
// MEM_ARB_WATCHDOG_EN is defined, otherwise the indefinite-wait behaviour is checked.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    checks++; if ({mem_req, mem_we, if_done, d_done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_done, d_done, err});
    end
    checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    rst_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: mem_req got %b want 0", mem_req);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL fetch_issue: got req=%b we=%b addr=%h want 1 0 00000100", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    checks++; if ({if_done, d_done, if_rdata} !== {1'b1, 1'b0, 32'h13}) begin
      errors++; $display("FAIL fetch_done: got if_done=%b d_done=%b rdata=%h want 1 0 00000013", if_done, d_done, if_rdata);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++; if ({if_done, mem_req} !== 2'b00) begin
      errors++; $display("FAIL fetch_pulse: got if_done=%b mem_req=%b want 0 0", if_done, mem_req);
    end
  endtask

  task automatic test_priority();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL prio_store: got req=%b we=%b addr=%h wdata=%h want 1 1 00000200 deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0;
    tick();
    checks++; if ({d_done, if_done, mem_req} !== 3'b100) begin
      errors++; $display("FAIL prio_d_done: got d_done=%b if_done=%b mem_req=%b want 1 0 0", d_done, if_done, mem_req);
    end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h300}) begin
      errors++; $display("FAIL prio_fetch: got req=%b we=%b addr=%h want 1 0 00000300", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    checks++; if ({if_done, d_done, if_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
      errors++; $display("FAIL prio_if_done: got if_done=%b d_done=%b rdata=%h want 1 0 cafe0001", if_done, d_done, if_rdata);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_wait_load();
    int req_cycles = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (mem_req === 1'b1 && d_done === 1'b0) req_cycles++;
      if (i == 5) begin mem_ready = 1'b1; mem_rdata = 32'h1234_5678; end
      tick();
    end
    checks++; if (req_cycles !== 5) begin
      errors++; $display("FAIL wait_req_cycles: got %0d want 5", req_cycles);
    end
    checks++; if ({d_done, d_rdata, mem_req} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      errors++; $display("FAIL wait_done: got d_done=%b rdata=%h mem_req=%b want 1 12345678 0", d_done, d_rdata, mem_req);
    end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_ignore_idle();
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    checks++; if ({if_done, d_done, mem_req, d_rdata} !== {3'b000, 32'h1234_5678}) begin
      errors++; $display("FAIL idle_ready: got if_done=%b d_done=%b mem_req=%b d_rdata=%h want 0 0 0 12345678", if_done, d_done, mem_req, d_rdata);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stray_done = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, err} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got req=%b addr=%h d_rdata=%h want all 0", mem_req, mem_addr, d_rdata);
    end
    d_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (d_done !== 1'b0 || mem_req !== 1'b0) stray_done++;
    end
    checks++; if (stray_done !== 0) begin
      errors++; $display("FAIL rst_mid_idle: got %0d busy/done cycles want 0", stray_done);
    end
  endtask

  task automatic test_drop_req();
    int done_cnt = 0;
    if_req = 1'b1; if_addr = 32'h104;
    tick();
    if_req = 1'b0;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
      errors++; $display("FAIL drop_hold: got req=%b addr=%h want 1 00000104", mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h55;
    tick();
    checks++; if ({if_done, if_rdata} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL drop_done: got if_done=%b rdata=%h want 1 00000055", if_done, if_rdata);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin
      errors++; $display("FAIL drop_single_pulse: got %0d extra pulses want 0", done_cnt);
    end
  endtask

  task automatic test_watchdog();
    int req_cycles = 0;
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b0;
    tick();
    if_req = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
    for (int i = 0; i < 16; i++) begin
      if (mem_req === 1'b1 && if_done === 1'b0 && err === 1'b0) req_cycles++;
      tick();
    end
    checks++; if (req_cycles !== 16) begin
      errors++; $display("FAIL wd_wait: got %0d wait cycles want 16", req_cycles);
    end
    checks++; if ({if_done, if_rdata, err, mem_req} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wd_timeout: got if_done=%b rdata=%h err=%b mem_req=%b want 1 0 1 0", if_done, if_rdata, err, mem_req);
    end
    tick(); tick(); tick();
    checks++; if ({err, if_done} !== 2'b10) begin
      errors++; $display("FAIL wd_sticky: got err=%b if_done=%b want 1 0", err, if_done);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL wd_err_clear: got %b want 0", err);
    end
    tick();
    rst_n = 1'b1;
    tick();
`else
    for (int i = 0; i < 24; i++) begin
      if (mem_req === 1'b1 && if_done === 1'b0 && err === 1'b0) req_cycles++;
      tick();
    end
    checks++; if (req_cycles !== 24) begin
      errors++; $display("FAIL nowd_wait: got %0d wait cycles want 24", req_cycles);
    end
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0F0F;
    tick();
    checks++; if ({if_done, if_rdata, err} !== {1'b1, 32'hA5A5_0F0F, 1'b0}) begin
      errors++; $display("FAIL nowd_done: got if_done=%b rdata=%h err=%b want 1 a5a50f0f 0", if_done, if_rdata, err);
    end
    mem_ready = 1'b0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_wait_load();
    test_ignore_idle();
    test_reset_mid();
    test_drop_req();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
